galaga_duel_core: RTL and testbench

Parametrised two-player duel controller for the Galaga project. It is the successor to the fixed 3-lane ship/armour/game FSMs.
- Tracks each ship's lane over LANES positions and resolves shots between aligned ships.
- Consumes armour before lives, enforces a per-player fire cooldown.
- Runs an IDLE/PLAY/OVER game FSM with DONE and WINNER outputs for the display and score logic.

---
 rtl/galaga_duel_core.sv | 209 ++++++++++++++++++++
 tb/tb_galaga_duel_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/galaga_duel_core.sv
// galaga_duel_core
// Two-player duel controller: per-ship lane tracking, shot resolution between
// aligned ships, armour-before-lives damage, per-player fire cooldown, and an
// IDLE/PLAY/OVER game FSM.
//
// Ports:
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   START              start/restart request (honoured in IDLE and OVER)
//   LEFTx/RIGHTx/FIREx ship x controls
//   POS1/POS2          ship lanes, 0 = leftmost
//   ALIGN              ships share a lane
//   ARMOR1/2, LIVES1/2 remaining armour and lives
//   STATE              00 IDLE, 01 PLAY, 10 OVER
//   DONE               high while in OVER
//   WINNER             00 none, 01 player 1, 10 player 2
module galaga_duel_core #(
    parameter int LANES    = 3,
    parameter int POS_W    = 2,
    parameter int LIVES    = 3,
    parameter int LIFE_W   = 3,
    parameter int ARMOR    = 1,
    parameter int ARM_W    = 2,
    parameter int COOLDOWN = 2,
    parameter int CD_W     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              LEFT1,
    input  logic              RIGHT1,
    input  logic              FIRE1,
    input  logic              LEFT2,
    input  logic              RIGHT2,
    input  logic              FIRE2,
    output logic [POS_W-1:0]  POS1,
    output logic [POS_W-1:0]  POS2,
    output logic              ALIGN,
    output logic [ARM_W-1:0]  ARMOR1,
    output logic [ARM_W-1:0]  ARMOR2,
    output logic [LIFE_W-1:0] LIVES1,
    output logic [LIFE_W-1:0] LIVES2,
    output logic [1:0]        STATE,
    output logic              DONE,
    output logic [1:0]        WINNER
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    localparam logic [POS_W-1:0]  POS_CTR   = POS_W'(LANES / 2);
    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(LANES - 1);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIVES);
    localparam logic [ARM_W-1:0]  ARM_INIT  = ARM_W'(ARMOR);
    localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(COOLDOWN);

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos1_q, pos1_d, pos2_q, pos2_d;
    logic [ARM_W-1:0]   armor1_q, armor1_d, armor2_q, armor2_d;
    logic [LIFE_W-1:0]  lives1_q, lives1_d, lives2_q, lives2_d;
    logic [CD_W-1:0]    cd1_q, cd1_d, cd2_q, cd2_d;
    logic [1:0]         winner_q, winner_d;

    logic shot1, shot2, align, hit1, hit2, dead1, dead2;

    // Saturating one-lane move; both or neither direction holds.
    function automatic logic [POS_W-1:0] move(input logic [POS_W-1:0] pos,
                                              input logic l, input logic r);
        logic [POS_W-1:0] res;
        res = pos;
        if (l && !r && pos != '0)
            res = pos - POS_W'(1);
        else if (r && !l && pos != POS_MAX)
            res = pos + POS_W'(1);
        return res;
    endfunction

    // A valid shot reloads the cooldown; otherwise count down and stick at 0.
    function automatic logic [CD_W-1:0] next_cd(input logic [CD_W-1:0] cd,
                                                input logic shot);
        logic [CD_W-1:0] res;
        if (shot)
            res = CD_INIT;
        else if (cd != '0)
            res = cd - CD_W'(1);
        else
            res = '0;
        return res;
    endfunction

    // Armour absorbs a hit first; the last life going flags the ship dead.
    function automatic void take_hit(input  logic [ARM_W-1:0]  arm,
                                     input  logic [LIFE_W-1:0] lives,
                                     output logic [ARM_W-1:0]  arm_n,
                                     output logic [LIFE_W-1:0] lives_n,
                                     output logic              dead);
        arm_n   = arm;
        lives_n = lives;
        dead    = 1'b0;
        if (arm != '0) begin
            arm_n = arm - ARM_W'(1);
        end else if (lives > LIFE_W'(1)) begin
            lives_n = lives - LIFE_W'(1);
        end else begin
            lives_n = '0;
            dead    = 1'b1;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        pos1_d   = pos1_q;
        pos2_d   = pos2_q;
        armor1_d = armor1_q;
        armor2_d = armor2_q;
        lives1_d = lives1_q;
        lives2_d = lives2_q;
        cd1_d    = cd1_q;
        cd2_d    = cd2_q;
        winner_d = winner_q;
        dead1    = 1'b0;
        dead2    = 1'b0;

        // Hits are judged on the registered (pre-move) positions.
        align = (pos1_q == pos2_q);
        shot1 = FIRE1 && (cd1_q == '0);
        shot2 = FIRE2 && (cd2_q == '0);
        hit2  = shot1 && !shot2 && align;
        hit1  = shot2 && !shot1 && align;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (START) begin
                    state_d  = S_PLAY;
                    pos1_d   = POS_CTR;
                    pos2_d   = POS_CTR;
                    armor1_d = ARM_INIT;
                    armor2_d = ARM_INIT;
                    lives1_d = LIFE_INIT;
                    lives2_d = LIFE_INIT;
                    cd1_d    = '0;
                    cd2_d    = '0;
                    winner_d = 2'b00;
                end
            end
            S_PLAY: begin
                pos1_d = move(pos1_q, LEFT1, RIGHT1);
                pos2_d = move(pos2_q, LEFT2, RIGHT2);
                cd1_d  = next_cd(cd1_q, shot1);
                cd2_d  = next_cd(cd2_q, shot2);
                if (hit2) begin
                    take_hit(armor2_q, lives2_q, armor2_d, lives2_d, dead2);
                    if (dead2) begin
                        state_d  = S_OVER;
                        winner_d = 2'b01;
                    end
                end
                if (hit1) begin
                    take_hit(armor1_q, lives1_q, armor1_d, lives1_d, dead1);
                    if (dead1) begin
                        state_d  = S_OVER;
                        winner_d = 2'b10;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            pos1_q   <= POS_CTR;
            pos2_q   <= POS_CTR;
            armor1_q <= ARM_INIT;
            armor2_q <= ARM_INIT;
            lives1_q <= LIFE_INIT;
            lives2_q <= LIFE_INIT;
            cd1_q    <= '0;
            cd2_q    <= '0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            pos1_q   <= pos1_d;
            pos2_q   <= pos2_d;
            armor1_q <= armor1_d;
            armor2_q <= armor2_d;
            lives1_q <= lives1_d;
            lives2_q <= lives2_d;
            cd1_q    <= cd1_d;
            cd2_q    <= cd2_d;
            winner_q <= winner_d;
        end
    end

    assign POS1   = pos1_q;
    assign POS2   = pos2_q;
    assign ALIGN  = align;
    assign ARMOR1 = armor1_q;
    assign ARMOR2 = armor2_q;
    assign LIVES1 = lives1_q;
    assign LIVES2 = lives2_q;
    assign STATE  = state_q;
    assign DONE   = (state_q == S_OVER);
    assign WINNER = winner_q;

endmodule

// File: tb/tb_galaga_duel_core.sv
// tb_galaga_duel_core
// Table-driven bench for galaga_duel_core with default parameters
// (3 lanes, 3 lives, 1 armour, cooldown 2). Each vector is driven for one
// clock; its expected outputs go into a scoreboard queue and are popped and
// compared after the edge. Reset behaviour is checked by hand.
module tb_galaga_duel_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START, LEFT1, RIGHT1, FIRE1, LEFT2, RIGHT2, FIRE2;
    logic [1:0] POS1, POS2;
    logic       ALIGN;
    logic [1:0] ARMOR1, ARMOR2;
    logic [2:0] LIVES1, LIVES2;
    logic [1:0] STATE;
    logic       DONE;
    logic [1:0] WINNER;

    int tests_run = 0;
    int tests_failed = 0;

    galaga_duel_core dut (
        .CLK(CLK), .RST(RST), .START(START),
        .LEFT1(LEFT1), .RIGHT1(RIGHT1), .FIRE1(FIRE1),
        .LEFT2(LEFT2), .RIGHT2(RIGHT2), .FIRE2(FIRE2),
        .POS1(POS1), .POS2(POS2), .ALIGN(ALIGN),
        .ARMOR1(ARMOR1), .ARMOR2(ARMOR2),
        .LIVES1(LIVES1), .LIVES2(LIVES2),
        .STATE(STATE), .DONE(DONE), .WINNER(WINNER)
    );

    always #5 CLK = ~CLK;

    // in = {START, LEFT1, RIGHT1, FIRE1, LEFT2, RIGHT2, FIRE2}
    typedef struct {
        logic [6:0] in;
        int p1, p2, a1, a2, v1, v2, st, w;
    } vec_t;

    typedef struct {
        int id;
        int p1, p2, a1, a2, v1, v2, st, w;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic [6:0] in, input int p1, input int p2,
                                input int a1, input int a2, input int v1,
                                input int v2, input int st, input int w);
        vec_t v;
        v.in = in; v.p1 = p1; v.p2 = p2; v.a1 = a1; v.a2 = a2;
        v.v1 = v1; v.v2 = v2; v.st = st; v.w = w;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " POS1"},   POS1,   e.p1);
        check({tag, " POS2"},   POS2,   e.p2);
        check({tag, " ALIGN"},  ALIGN,  (e.p1 == e.p2) ? 1 : 0);
        check({tag, " ARMOR1"}, ARMOR1, e.a1);
        check({tag, " ARMOR2"}, ARMOR2, e.a2);
        check({tag, " LIVES1"}, LIVES1, e.v1);
        check({tag, " LIVES2"}, LIVES2, e.v2);
        check({tag, " STATE"},  STATE,  e.st);
        check({tag, " DONE"},   DONE,   (e.st == 2) ? 1 : 0);
        check({tag, " WINNER"}, WINNER, e.w);
    endtask

    task automatic apply_vec(input int id, input vec_t v);
        exp_t e, got;
        @(negedge CLK);
        {START, LEFT1, RIGHT1, FIRE1, LEFT2, RIGHT2, FIRE2} = v.in;
        e.id = id; e.p1 = v.p1; e.p2 = v.p2; e.a1 = v.a1; e.a2 = v.a2;
        e.v1 = v.v1; e.v2 = v.v2; e.st = v.st; e.w = v.w;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard empty", 0, 1);
        end else begin
            got = sb.pop_front();
            check_all($sformatf("v%0d", got.id), got);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        exp_t e;
        e.id = -1; e.p1 = 1; e.p2 = 1; e.a1 = 1; e.a2 = 1;
        e.v1 = 3; e.v2 = 3; e.st = 0; e.w = 0;
        check_all(tag, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                       SLRFLRF  p1 p2 a1 a2 v1 v2 st w
        tbl.push_back(mk(7'b0010000, 1, 1, 1, 1, 3, 3, 0, 0)); // 0 IDLE ignores move
        tbl.push_back(mk(7'b1000000, 1, 1, 1, 1, 3, 3, 1, 0)); // 1 START
        tbl.push_back(mk(7'b0010100, 2, 0, 1, 1, 3, 3, 1, 0)); // 2 R1/L2
        tbl.push_back(mk(7'b0010100, 2, 0, 1, 1, 3, 3, 1, 0)); // 3 saturate
        tbl.push_back(mk(7'b0010100, 2, 0, 1, 1, 3, 3, 1, 0)); // 4
        tbl.push_back(mk(7'b0010100, 2, 0, 1, 1, 3, 3, 1, 0)); // 5
        tbl.push_back(mk(7'b0100010, 1, 1, 1, 1, 3, 3, 1, 0)); // 6 realign
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 0, 3, 3, 1, 0)); // 7 armour hit
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 0, 3, 3, 1, 0)); // 8 cooldown
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 0, 3, 3, 1, 0)); // 9 cooldown
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 0, 3, 2, 1, 0)); // 10 4th cycle shot
        tbl.push_back(mk(7'b0000000, 1, 1, 1, 0, 3, 2, 1, 0)); // 11
        tbl.push_back(mk(7'b0000000, 1, 1, 1, 0, 3, 2, 1, 0)); // 12
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 0, 3, 1, 1, 0)); // 13
        tbl.push_back(mk(7'b0000000, 1, 1, 1, 0, 3, 1, 1, 0)); // 14
        tbl.push_back(mk(7'b0000000, 1, 1, 1, 0, 3, 1, 1, 0)); // 15
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 0, 3, 0, 2, 1)); // 16 kill -> OVER
        tbl.push_back(mk(7'b0101011, 1, 1, 1, 0, 3, 0, 2, 1)); // 17 frozen
        tbl.push_back(mk(7'b0010101, 1, 1, 1, 0, 3, 0, 2, 1)); // 18 frozen
        tbl.push_back(mk(7'b1000000, 1, 1, 1, 1, 3, 3, 1, 0)); // 19 restart
        tbl.push_back(mk(7'b0001001, 1, 1, 1, 1, 3, 3, 1, 0)); // 20 collide
        tbl.push_back(mk(7'b0001000, 1, 1, 1, 1, 3, 3, 1, 0)); // 21 cd1 loaded
        tbl.push_back(mk(7'b0000001, 1, 1, 1, 1, 3, 3, 1, 0)); // 22 cd2 loaded
        tbl.push_back(mk(7'b0010001, 2, 1, 0, 1, 3, 3, 1, 0)); // 23 fire+move
        tbl.push_back(mk(7'b1100000, 1, 1, 0, 1, 3, 3, 1, 0)); // 24 START ignored
        tbl.push_back(mk(7'b0000000, 1, 1, 0, 1, 3, 3, 1, 0)); // 25
        tbl.push_back(mk(7'b0000001, 1, 1, 0, 1, 2, 3, 1, 0)); // 26 lives1 -> 2
        tbl.push_back(mk(7'b0010000, 2, 1, 0, 1, 2, 3, 1, 0)); // 27 split
        tbl.push_back(mk(7'b0001000, 2, 1, 0, 1, 2, 3, 1, 0)); // 28 miss
        tbl.push_back(mk(7'b0100000, 1, 1, 0, 1, 2, 3, 1, 0)); // 29 realign
        tbl.push_back(mk(7'b0001000, 1, 1, 0, 1, 2, 3, 1, 0)); // 30 cd after miss
        tbl.push_back(mk(7'b0001000, 1, 1, 0, 0, 2, 3, 1, 0)); // 31 hit
        tbl.push_back(mk(7'b0010000, 2, 1, 0, 0, 2, 3, 1, 0)); // 32 move before RST

        {START, LEFT1, RIGHT1, FIRE1, LEFT2, RIGHT2, FIRE2} = 7'b0;
        RST = 1'b1;
        #2;
        check_reset_vals("reset");
        @(negedge CLK);
        RST = 1'b0;

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // Asynchronous reset mid-game, between edges.
        #2;
        RST = 1'b1;
        #1;
        check_reset_vals("async rst");
        @(negedge CLK);
        RST = 1'b0;

        // First edges after release behave as IDLE, then a fresh game.
        apply_vec(100, mk(7'b0011001, 1, 1, 1, 1, 3, 3, 0, 0));
        apply_vec(101, mk(7'b1000000, 1, 1, 1, 1, 3, 3, 1, 0));
        apply_vec(102, mk(7'b0100100, 0, 0, 1, 1, 3, 3, 1, 0));
        apply_vec(103, mk(7'b0100100, 0, 0, 1, 1, 3, 3, 1, 0));

        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
